// File: rtl/rat_arf_mp.sv
// Register alias table merged with the architectural register file: per register it holds
// committed data, a ready bit and the ROB tag of the youngest in-flight producer.
module rat_arf_mp #(
    parameter int unsigned NUM_REGS      = 32,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_IDX_WIDTH = 5,
    parameter int unsigned DISP_W        = 2,
    parameter int unsigned CMT_W         = 2,
    localparam int unsigned AW           = $clog2(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic [DISP_W-1:0]                 disp_valid_i,
    input  logic [DISP_W*AW-1:0]              disp_rd_addr_i,
    input  logic [DISP_W*ROB_IDX_WIDTH-1:0]   disp_rob_idx_i,
    input  logic [DISP_W*AW-1:0]              disp_rs1_addr_i,
    input  logic [DISP_W*AW-1:0]              disp_rs2_addr_i,
    output logic [DISP_W*XLEN-1:0]            rs1_data_o,
    output logic [DISP_W*XLEN-1:0]            rs2_data_o,
    output logic [DISP_W-1:0]                 rs1_ready_o,
    output logic [DISP_W-1:0]                 rs2_ready_o,
    output logic [DISP_W*ROB_IDX_WIDTH-1:0]   rs1_rob_idx_o,
    output logic [DISP_W*ROB_IDX_WIDTH-1:0]   rs2_rob_idx_o,
    input  logic [CMT_W-1:0]                  cmt_valid_i,
    input  logic [CMT_W*AW-1:0]               cmt_rd_addr_i,
    input  logic [CMT_W*ROB_IDX_WIDTH-1:0]    cmt_rob_idx_i,
    input  logic [CMT_W*XLEN-1:0]             cmt_data_i
);

    logic [XLEN-1:0]          data_q [NUM_REGS];
    logic [XLEN-1:0]          data_d [NUM_REGS];
    logic [ROB_IDX_WIDTH-1:0] tag_q  [NUM_REGS];
    logic [ROB_IDX_WIDTH-1:0] tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0]      ready_q;
    logic [NUM_REGS-1:0]      ready_d;

    // Next state: commits first (checked against the old tag), then flush or renames on top.
    always_comb begin
        logic [AW-1:0] rd;
        data_d  = data_q;
        tag_d   = tag_q;
        ready_d = ready_q;
        rd      = '0;

        for (int j = 0; j < int'(CMT_W); j++) begin
            rd = cmt_rd_addr_i[j*AW +: AW];
            if (cmt_valid_i[j] && (rd != '0)) begin
                data_d[rd] = cmt_data_i[j*XLEN +: XLEN];
                if (tag_q[rd] == cmt_rob_idx_i[j*ROB_IDX_WIDTH +: ROB_IDX_WIDTH]) begin
                    ready_d[rd] = 1'b1;
                end
            end
        end

        if (flush_i) begin
            ready_d = '1;
        end else begin
            for (int i = 0; i < int'(DISP_W); i++) begin
                rd = disp_rd_addr_i[i*AW +: AW];
                if (disp_valid_i[i] && (rd != '0)) begin
                    tag_d[rd]   = disp_rob_idx_i[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
                    ready_d[rd] = 1'b0;
                end
            end
        end

        // x0 is hardwired
        data_d[0]  = '0;
        tag_d[0]   = '0;
        ready_d[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            ready_q <= '1;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            ready_q <= ready_d;
        end
    end

    // Source lookup: stored state, then commit bypass, then older in-bundle producers override.
    always_comb begin
        logic [AW-1:0]            src;
        logic                     rdy;
        logic [ROB_IDX_WIDTH-1:0] tg;
        logic [XLEN-1:0]          dat;
        rs1_data_o    = '0;
        rs2_data_o    = '0;
        rs1_ready_o   = '0;
        rs2_ready_o   = '0;
        rs1_rob_idx_o = '0;
        rs2_rob_idx_o = '0;
        src = '0;
        rdy = 1'b0;
        tg  = '0;
        dat = '0;

        for (int i = 0; i < int'(DISP_W); i++) begin
            for (int s = 0; s < 2; s++) begin
                src = (s == 0) ? disp_rs1_addr_i[i*AW +: AW] : disp_rs2_addr_i[i*AW +: AW];
                rdy = ready_q[src];
                tg  = tag_q[src];
                dat = data_q[src];

                if (!rdy) begin
                    for (int j = 0; j < int'(CMT_W); j++) begin
                        if (cmt_valid_i[j] && (cmt_rd_addr_i[j*AW +: AW] == src) &&
                            (cmt_rob_idx_i[j*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == tag_q[src])) begin
                            rdy = 1'b1;
                            dat = cmt_data_i[j*XLEN +: XLEN];
                        end
                    end
                end

                for (int k = 0; k < int'(DISP_W); k++) begin
                    if ((k < i) && disp_valid_i[k] && (src != '0) &&
                        (disp_rd_addr_i[k*AW +: AW] == src)) begin
                        rdy = 1'b0;
                        tg  = disp_rob_idx_i[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
                        dat = '0;
                    end
                end

                if (s == 0) begin
                    rs1_ready_o[i]                                  = rdy;
                    rs1_rob_idx_o[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] = tg;
                    rs1_data_o[i*XLEN +: XLEN]                      = dat;
                end else begin
                    rs2_ready_o[i]                                  = rdy;
                    rs2_rob_idx_o[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] = tg;
                    rs2_data_o[i*XLEN +: XLEN]                      = dat;
                end
            end
        end
    end

endmodule

// File: tb/tb_rat_arf_mp.sv
// Randomised bench for rat_arf_mp against an array-based reference model, plus directed scenarios.
module tb_rat_arf_mp;
    localparam int NR = 32;
    localparam int XL = 32;
    localparam int RW = 5;
    localparam int DW = 2;
    localparam int CW = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    logic [DW-1:0] dv;
    logic [AW-1:0] d_rd [DW];
    logic [AW-1:0] d_rs1[DW];
    logic [AW-1:0] d_rs2[DW];
    logic [RW-1:0] d_tag[DW];
    logic [CW-1:0] cv;
    logic [AW-1:0] c_rd [CW];
    logic [RW-1:0] c_tag[CW];
    logic [XL-1:0] c_dat[CW];

    logic [DW*AW-1:0] disp_rd_f, disp_rs1_f, disp_rs2_f;
    logic [DW*RW-1:0] disp_tag_f;
    logic [CW*AW-1:0] cmt_rd_f;
    logic [CW*RW-1:0] cmt_tag_f;
    logic [CW*XL-1:0] cmt_dat_f;
    logic [DW*XL-1:0] rs1_data, rs2_data;
    logic [DW-1:0]    rs1_ready, rs2_ready;
    logic [DW*RW-1:0] rs1_rob, rs2_rob;

    assign disp_rd_f  = {d_rd[1],  d_rd[0]};
    assign disp_rs1_f = {d_rs1[1], d_rs1[0]};
    assign disp_rs2_f = {d_rs2[1], d_rs2[0]};
    assign disp_tag_f = {d_tag[1], d_tag[0]};
    assign cmt_rd_f   = {c_rd[1],  c_rd[0]};
    assign cmt_tag_f  = {c_tag[1], c_tag[0]};
    assign cmt_dat_f  = {c_dat[1], c_dat[0]};

    rat_arf_mp dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .disp_valid_i(dv), .disp_rd_addr_i(disp_rd_f), .disp_rob_idx_i(disp_tag_f),
        .disp_rs1_addr_i(disp_rs1_f), .disp_rs2_addr_i(disp_rs2_f),
        .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
        .rs1_ready_o(rs1_ready), .rs2_ready_o(rs2_ready),
        .rs1_rob_idx_o(rs1_rob), .rs2_rob_idx_o(rs2_rob),
        .cmt_valid_i(cv), .cmt_rd_addr_i(cmt_rd_f), .cmt_rob_idx_i(cmt_tag_f), .cmt_data_i(cmt_dat_f)
    );

    // Reference state
    logic [XL-1:0] m_data [NR];
    logic          m_ready[NR];
    logic [RW-1:0] m_tag  [NR];

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        else n_pass++;
    endtask

    function automatic void exp_lookup(input int lane, input logic [AW-1:0] rs,
                                       output logic rdy, output logic [RW-1:0] tg,
                                       output logic [XL-1:0] dat);
        int prod = -1;
        if (rs == 0) begin
            rdy = 1'b1; tg = '0; dat = '0;
            return;
        end
        for (int k = 0; k < lane; k++) if (dv[k] && d_rd[k] == rs) prod = k;
        if (prod >= 0) begin
            rdy = 1'b0; tg = d_tag[prod]; dat = '0;
        end else if (m_ready[rs]) begin
            rdy = 1'b1; tg = m_tag[rs]; dat = m_data[rs];
        end else begin
            rdy = 1'b0; tg = m_tag[rs]; dat = m_data[rs];
            for (int j = CW - 1; j >= 0; j--) begin
                if (cv[j] && c_rd[j] == rs && c_tag[j] == m_tag[rs]) begin
                    rdy = 1'b1; dat = c_dat[j];
                    break;
                end
            end
        end
    endfunction

    task automatic check_all();
        logic rdy;
        logic [RW-1:0] tg;
        logic [XL-1:0] dat;
        for (int i = 0; i < DW; i++) begin
            exp_lookup(i, d_rs1[i], rdy, tg, dat);
            chk($sformatf("lane%0d rs1=%0d ready", i, d_rs1[i]), 64'(rs1_ready[i]), 64'(rdy));
            chk($sformatf("lane%0d rs1=%0d data", i, d_rs1[i]), 64'(rs1_data[i*XL +: XL]), 64'(dat));
            chk($sformatf("lane%0d rs1=%0d tag", i, d_rs1[i]), 64'(rs1_rob[i*RW +: RW]), 64'(tg));
            exp_lookup(i, d_rs2[i], rdy, tg, dat);
            chk($sformatf("lane%0d rs2=%0d ready", i, d_rs2[i]), 64'(rs2_ready[i]), 64'(rdy));
            chk($sformatf("lane%0d rs2=%0d data", i, d_rs2[i]), 64'(rs2_data[i*XL +: XL]), 64'(dat));
            chk($sformatf("lane%0d rs2=%0d tag", i, d_rs2[i]), 64'(rs2_rob[i*RW +: RW]), 64'(tg));
        end
    endtask

    task automatic model_update();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_data[r] = '0; m_ready[r] = 1'b1; m_tag[r] = '0;
            end
            return;
        end
        for (int j = 0; j < CW; j++) begin
            if (cv[j] && c_rd[j] != 0) begin
                m_data[c_rd[j]] = c_dat[j];
                if (c_tag[j] == m_tag[c_rd[j]]) m_ready[c_rd[j]] = 1'b1;
            end
        end
        if (flush) begin
            for (int r = 0; r < NR; r++) m_ready[r] = 1'b1;
        end else begin
            for (int i = 0; i < DW; i++) begin
                if (dv[i] && d_rd[i] != 0) begin
                    m_tag[d_rd[i]] = d_tag[i]; m_ready[d_rd[i]] = 1'b0;
                end
            end
        end
    endtask

    task automatic clr();
        flush = 1'b0; dv = '0; cv = '0;
        for (int i = 0; i < DW; i++) begin
            d_rd[i] = '0; d_rs1[i] = '0; d_rs2[i] = '0; d_tag[i] = '0;
        end
        for (int j = 0; j < CW; j++) begin
            c_rd[j] = '0; c_tag[j] = '0; c_dat[j] = '0;
        end
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic disp(input int lane, input int rd, input int tag);
        dv[lane] = 1'b1; d_rd[lane] = AW'(rd); d_tag[lane] = RW'(tag);
    endtask

    task automatic cmt(input int lane, input int rd, input int tag, input logic [XL-1:0] dat);
        cv[lane] = 1'b1; c_rd[lane] = AW'(rd); c_tag[lane] = RW'(tag); c_dat[lane] = dat;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        d_rs1[0] = 5;
        settle();
        chk("reset x5 ready", 64'(rs1_ready[0]), 64'd1);
        chk("reset x5 data", 64'(rs1_data[31:0]), 64'd0);
        chk("reset x5 tag", 64'(rs1_rob[4:0]), 64'd0);
        cmt(0, 5, 0, 32'hDEAD_BEEF);
        tick();
        clr(); d_rs1[0] = 5;
        settle();
        chk("x5 after commit data", 64'(rs1_data[31:0]), 64'hDEADBEEF);
        chk("x5 after commit ready", 64'(rs1_ready[0]), 64'd1);
        tick();

        // rename then bypass
        clr(); disp(0, 3, 4);
        settle();
        tick();
        clr(); d_rs1[0] = 3;
        settle();
        chk("x3 renamed ready", 64'(rs1_ready[0]), 64'd0);
        chk("x3 renamed tag", 64'(rs1_rob[4:0]), 64'd4);
        cmt(0, 3, 4, 32'h55);
        settle();
        chk("x3 bypass ready", 64'(rs1_ready[0]), 64'd1);
        chk("x3 bypass data", 64'(rs1_data[31:0]), 64'h55);
        tick();
        clr(); d_rs1[0] = 3;
        settle();
        chk("x3 stored ready", 64'(rs1_ready[0]), 64'd1);
        chk("x3 stored data", 64'(rs1_data[31:0]), 64'h55);
        tick();

        // intra-bundle dependency
        clr(); disp(0, 7, 2); d_rs1[0] = 7; d_rs1[1] = 7;
        settle();
        chk("intra lane1 ready", 64'(rs1_ready[1]), 64'd0);
        chk("intra lane1 tag", 64'(rs1_rob[9:5]), 64'd2);
        chk("intra lane0 ready", 64'(rs1_ready[0]), 64'd1);
        tick();

        // WAW inside one bundle
        clr(); disp(0, 9, 1); disp(1, 9, 6);
        settle(); tick();
        clr(); cmt(0, 9, 1, 32'h111);
        settle(); tick();
        clr(); d_rs1[0] = 9;
        settle();
        chk("waw stale ready", 64'(rs1_ready[0]), 64'd0);
        chk("waw tag", 64'(rs1_rob[4:0]), 64'd6);
        chk("waw stale data", 64'(rs1_data[31:0]), 64'h111);
        cmt(1, 9, 6, 32'h666);
        tick();
        clr(); d_rs1[0] = 9;
        settle();
        chk("waw final ready", 64'(rs1_ready[0]), 64'd1);
        chk("waw final data", 64'(rs1_data[31:0]), 64'h666);
        tick();

        // dispatch overrides same-cycle commit ready
        clr(); disp(0, 4, 2);
        settle(); tick();
        clr(); cmt(0, 4, 2, 32'h44); disp(0, 4, 8);
        settle(); tick();
        clr(); d_rs1[0] = 4;
        settle();
        chk("x4 override ready", 64'(rs1_ready[0]), 64'd0);
        chk("x4 override tag", 64'(rs1_rob[4:0]), 64'd8);
        chk("x4 override data", 64'(rs1_data[31:0]), 64'h44);
        tick();

        // flush with concurrent dispatch
        clr(); disp(0, 11, 5); disp(1, 12, 7);
        settle(); tick();
        clr(); flush = 1'b1; disp(0, 10, 3);
        settle(); tick();
        clr(); d_rs1[0] = 11; d_rs2[0] = 12; d_rs1[1] = 10; d_rs2[1] = 4;
        settle();
        chk("flush x11 ready", 64'(rs1_ready[0]), 64'd1);
        chk("flush x12 ready", 64'(rs2_ready[0]), 64'd1);
        chk("flush x10 ready", 64'(rs1_ready[1]), 64'd1);
        chk("flush x10 data", 64'(rs1_data[63:32]), 64'd0);
        chk("flush x4 data", 64'(rs2_data[63:32]), 64'h44);
        chk("model x10 ready", 64'(m_ready[10]), 64'd1);
        chk("model x9 data", 64'(m_data[9]), 64'h666);
        tick();

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < DW; i++) begin
                dv[i]    = 1'($urandom_range(0, 1));
                d_rd[i]  = AW'($urandom_range(0, 15));
                d_rs1[i] = AW'($urandom_range(0, 15));
                d_rs2[i] = AW'($urandom_range(0, 15));
                d_tag[i] = RW'($urandom());
            end
            for (int j = 0; j < CW; j++) begin
                cv[j]    = ($urandom_range(0, 2) != 0);
                c_rd[j]  = AW'($urandom_range(0, 15));
                c_tag[j] = ($urandom_range(0, 1) == 1) ? m_tag[c_rd[j]] : RW'($urandom());
                c_dat[j] = $urandom();
            end
            if (c_rd[1] == c_rd[0]) cv[1] = 1'b0;
            settle();
            tick();
        end

        // reset mid-stream
        clr(); rst = 1'b1; disp(0, 5, 9); cmt(0, 6, 1, 32'h1234);
        tick();
        rst = 1'b0; clr(); d_rs1[0] = 5; d_rs2[1] = 3;
        settle();
        chk("rst x5 data", 64'(rs1_data[31:0]), 64'd0);
        chk("rst x5 ready", 64'(rs1_ready[0]), 64'd1);
        chk("rst x3 tag", 64'(rs2_rob[9:5]), 64'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
